// File: rtl/fcp_tx_sched.sv
// Frame scheduler in front of fcp_tx_ctrl: fixed-priority arbitration of response/AFC/ping
// requests, frame parameter freezing, inter-frame gap and hung-frame timeout.
module fcp_tx_sched #(
    parameter int unsigned GAP_CYCLES     = 40,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rsp_req_i,
    input  logic [15:0] rsp_data_i,
    input  logic        afc_req_i,
    input  logic        ping_req_i,
    input  logic        cfg_tune_up_i,
    input  logic [7:0]  cfg_tune_cycle_i,
    input  logic        tx_done_i,
    output logic        tx_en_o,
    output logic        tx_type_o,
    output logic        tx_afc_o,
    output logic [15:0] tx_data_o,
    output logic        tune_up_o,
    output logic [7:0]  tune_cycle_o,
    output logic        rsp_gnt_o,
    output logic        afc_gnt_o,
    output logic        ping_gnt_o,
    output logic        frame_done_o,
    output logic        frame_timeout_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_type_q, tx_type_d;
    logic        tx_afc_q, tx_afc_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tune_up_q, tune_up_d;
    logic [7:0]  tune_cycle_q, tune_cycle_d;
    logic        rsp_gnt_q, rsp_gnt_d;
    logic        afc_gnt_q, afc_gnt_d;
    logic        ping_gnt_q, ping_gnt_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_timeout_q, frame_timeout_d;
    logic        busy_q, busy_d;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d         = state_q;
        to_cnt_d        = to_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        tx_en_d         = tx_en_q;
        tx_type_d       = tx_type_q;
        tx_afc_d        = tx_afc_q;
        tx_data_d       = tx_data_q;
        tune_up_d       = tune_up_q;
        tune_cycle_d    = tune_cycle_q;
        rsp_gnt_d       = 1'b0;
        afc_gnt_d       = 1'b0;
        ping_gnt_d      = 1'b0;
        frame_done_d    = 1'b0;
        frame_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rsp_req_i || afc_req_i || ping_req_i) begin
                    state_d      = ST_ACTIVE;
                    tx_en_d      = 1'b1;
                    to_cnt_d     = 16'd1;
                    gap_cnt_d    = 8'd0;
                    tune_up_d    = cfg_tune_up_i;
                    tune_cycle_d = cfg_tune_cycle_i;
                    // Fixed priority: response, then AFC ack, then ping
                    if (rsp_req_i) begin
                        rsp_gnt_d = 1'b1;
                        tx_type_d = 1'b1;
                        tx_afc_d  = 1'b0;
                        tx_data_d = rsp_data_i;
                    end else if (afc_req_i) begin
                        afc_gnt_d = 1'b1;
                        tx_type_d = 1'b1;
                        tx_afc_d  = 1'b1;
                        tx_data_d = 16'h0000;
                    end else begin
                        ping_gnt_d = 1'b1;
                        tx_type_d  = 1'b0;
                        tx_afc_d   = 1'b0;
                        tx_data_d  = 16'h0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // A done arriving on the timeout cycle still counts as a normal completion
                if (tx_done_i) begin
                    state_d      = ST_GAP;
                    tx_en_d      = 1'b0;
                    frame_done_d = 1'b1;
                    gap_cnt_d    = 8'd1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d         = ST_GAP;
                    tx_en_d         = 1'b0;
                    frame_timeout_d = 1'b1;
                    gap_cnt_d       = 8'd1;
                end else begin
                    to_cnt_d = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = (gap_cnt_q == 8'hFF) ? gap_cnt_q : gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            to_cnt_q        <= 16'd0;
            gap_cnt_q       <= 8'd0;
            tx_en_q         <= 1'b0;
            tx_type_q       <= 1'b0;
            tx_afc_q        <= 1'b0;
            tx_data_q       <= 16'h0000;
            tune_up_q       <= 1'b0;
            tune_cycle_q    <= 8'd0;
            rsp_gnt_q       <= 1'b0;
            afc_gnt_q       <= 1'b0;
            ping_gnt_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_timeout_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            to_cnt_q        <= to_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            tx_en_q         <= tx_en_d;
            tx_type_q       <= tx_type_d;
            tx_afc_q        <= tx_afc_d;
            tx_data_q       <= tx_data_d;
            tune_up_q       <= tune_up_d;
            tune_cycle_q    <= tune_cycle_d;
            rsp_gnt_q       <= rsp_gnt_d;
            afc_gnt_q       <= afc_gnt_d;
            ping_gnt_q      <= ping_gnt_d;
            frame_done_q    <= frame_done_d;
            frame_timeout_q <= frame_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign tx_en_o         = tx_en_q;
    assign tx_type_o       = tx_type_q;
    assign tx_afc_o        = tx_afc_q;
    assign tx_data_o       = tx_data_q;
    assign tune_up_o       = tune_up_q;
    assign tune_cycle_o    = tune_cycle_q;
    assign rsp_gnt_o       = rsp_gnt_q;
    assign afc_gnt_o       = afc_gnt_q;
    assign ping_gnt_o      = ping_gnt_q;
    assign frame_done_o    = frame_done_q;
    assign frame_timeout_o = frame_timeout_q;
    assign busy_o          = busy_q;

endmodule
